// File: rtl/if_fetch_stage.sv
// Instruction fetch: drives pc to memory, captures the word into IF/ID (0-cycle read, 1-cycle capture).
// Backpressure: stall holds pc and IF/ID; redirect overrides stall and flushes IF/ID.
module if_fetch_stage #(
    parameter logic [4:0]  START_PC = 5'd0,
    parameter logic [3:0]  HALT_OP  = 4'b1101,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             start,
    input  logic             stall,
    input  logic             redirect,
    input  logic [4:0]       redirect_pc,
    input  logic [19:0]      mem_q,
    output logic [4:0]       mem_addr,
    output logic [19:0]      if_instr,
    output logic [4:0]       if_pc,
    output logic             if_valid,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t           state, state_nxt;
    logic [4:0]       pc, pc_nxt;
    logic [19:0]      instr_nxt;
    logic [4:0]       ipc_nxt;
    logic             valid_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    assign mem_addr = pc;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state       <= IDLE;
            pc          <= START_PC;
            if_instr    <= 20'b0;
            if_pc       <= 5'b0;
            if_valid    <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            if_instr    <= instr_nxt;
            if_pc       <= ipc_nxt;
            if_valid    <= valid_nxt;
            halted      <= (state_nxt == HALT);
            fetch_count <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = if_instr;
        ipc_nxt   = if_pc;
        valid_nxt = if_valid;
        cnt_nxt   = fetch_count;
        case (state)
            IDLE: begin
                if (redirect) pc_nxt = redirect_pc;
                if (start)    state_nxt = RUN;
            end
            RUN: begin
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    instr_nxt = 20'b0;
                    ipc_nxt   = 5'b0;
                    valid_nxt = 1'b0;
                end else if (!stall) begin
                    instr_nxt = mem_q;
                    ipc_nxt   = pc;
                    valid_nxt = 1'b1;
                    if (fetch_count != '1) cnt_nxt = fetch_count + CNT_W'(1);
                    // The halt word is delivered but pc parks on it.
                    if (mem_q[19:16] == HALT_OP) state_nxt = HALT;
                    else                         pc_nxt    = pc + 5'd1;
                end
            end
            HALT: begin
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    instr_nxt = 20'b0;
                    ipc_nxt   = 5'b0;
                    valid_nxt = 1'b0;
                    state_nxt = RUN;
                end else if (!stall) begin
                    instr_nxt = 20'b0;
                    valid_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized and directed bench for if_fetch_stage against a cycle-level behavioural model.
module tb_if_fetch_stage;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [4:0]  redirect_pc = 5'd0;
    logic [19:0] mem_q, mem_q2;
    logic [4:0]  mem_addr, mem_addr2;
    logic [19:0] if_instr, if_instr2;
    logic [4:0]  if_pc, if_pc2;
    logic        if_valid, if_valid2, halted, halted2;
    logic [7:0]  fetch_count;
    logic [1:0]  fetch_count2;

    logic [19:0] mem [32];

    assign mem_q  = mem[mem_addr];
    assign mem_q2 = mem[mem_addr2];

    always #5 Clock = ~Clock;

    if_fetch_stage dut (
        .Clock(Clock), .Resetn(Resetn), .start(start), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .mem_q(mem_q),
        .mem_addr(mem_addr), .if_instr(if_instr), .if_pc(if_pc),
        .if_valid(if_valid), .halted(halted), .fetch_count(fetch_count)
    );

    if_fetch_stage #(.CNT_W(2)) dut_narrow (
        .Clock(Clock), .Resetn(Resetn), .start(start), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .mem_q(mem_q2),
        .mem_addr(mem_addr2), .if_instr(if_instr2), .if_pc(if_pc2),
        .if_valid(if_valid2), .halted(halted2), .fetch_count(fetch_count2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Reference model: mode 0=idle, 1=fetching, 2=halted.
    int          m_mode;
    int          m_pc;
    int          m_ipc;
    logic [19:0] m_instr;
    int          m_valid;
    int          m_cnt;
    int          m_cnt2;

    task automatic model_edge();
        logic [19:0] w;
        if (!Resetn) begin
            m_mode = 0; m_pc = 0; m_ipc = 0; m_instr = 20'h0; m_valid = 0;
            m_cnt = 0; m_cnt2 = 0;
            return;
        end
        if (m_mode == 0) begin
            if (redirect) m_pc = redirect_pc;
            if (start) m_mode = 1;
        end else if (redirect) begin
            m_pc = redirect_pc; m_instr = 20'h0; m_ipc = 0; m_valid = 0; m_mode = 1;
        end else if (m_mode == 1 && !stall) begin
            w = mem[m_pc];
            m_instr = w; m_ipc = m_pc; m_valid = 1;
            m_cnt  = (m_cnt  < 255) ? m_cnt + 1  : 255;
            m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
            if (w[19:16] == 4'hD) m_mode = 2;
            else m_pc = (m_pc + 1) % 32;
        end else if (m_mode == 2 && !stall) begin
            m_valid = 0; m_instr = 20'h0;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge Clock);
        #1;
        chk("mem_addr", 32'(mem_addr), 32'(m_pc));
        chk("if_instr", 32'(if_instr), 32'(m_instr));
        chk("if_pc", 32'(if_pc), 32'(m_ipc));
        chk("if_valid", 32'(if_valid), 32'(m_valid));
        chk("halted", 32'(halted), (m_mode == 2) ? 32'd1 : 32'd0);
        chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
        chk("fetch_count_w2", 32'(fetch_count2), 32'(m_cnt2));
    endtask

    initial begin
        logic [19:0] w;
        for (int i = 0; i < 32; i++) mem[i] = {4'hA, 16'(i * 37)};
        mem[0] = 20'hF001D;
        mem[1] = 20'hF101E;

        step(); step();
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_cnt", 32'(fetch_count), 32'd0);

        // Start-up and first two fetches
        Resetn = 1'b1; start = 1'b1; step(); start = 1'b0;
        chk("t1_bubble", 32'(if_valid), 32'd0);
        step();
        chk("t1_instr0", 32'(if_instr), 32'hF001D);
        chk("t1_pc0", 32'(if_pc), 32'd0);
        chk("t1_addr1", 32'(mem_addr), 32'd1);
        step();
        chk("t1_instr1", 32'(if_instr), 32'hF101E);
        chk("t1_cnt2", 32'(fetch_count), 32'd2);

        // Stall hold
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_hold_pc", 32'(if_pc), 32'd2);
            chk("t2_hold_addr", 32'(mem_addr), 32'd3);
            chk("t2_hold_cnt", 32'(fetch_count), 32'd3);
        end
        stall = 1'b0; step();
        chk("t2_release", 32'(if_pc), 32'd3);

        // Redirect beats stall
        stall = 1'b1; redirect = 1'b1; redirect_pc = 5'd7; step();
        chk("t3_flush", 32'(if_valid), 32'd0);
        chk("t3_addr", 32'(mem_addr), 32'd7);
        stall = 1'b0; redirect = 1'b0; step();
        chk("t3_pc7", 32'(if_pc), 32'd7);
        chk("t3_valid", 32'(if_valid), 32'd1);
        chk("t3_sat2", 32'(fetch_count2), 32'd3);

        // Halt and restart
        mem[4] = 20'hD0000;
        redirect = 1'b1; redirect_pc = 5'd0; step(); redirect = 1'b0;
        repeat (5) step();
        chk("t4_instr", 32'(if_instr), 32'hD0000);
        chk("t4_valid", 32'(if_valid), 32'd1);
        chk("t4_halted", 32'(halted), 32'd1);
        chk("t4_addr", 32'(mem_addr), 32'd4);
        step();
        chk("t4_drop", 32'(if_valid), 32'd0);
        chk("t4_park", 32'(mem_addr), 32'd4);
        redirect = 1'b1; step(); redirect = 1'b0;
        chk("t4_unhalt", 32'(halted), 32'd0);
        step();
        chk("t4_resume", 32'(if_valid), 32'd1);
        mem[4] = 20'h14444;

        // PC wrap
        redirect = 1'b1; redirect_pc = 5'd31; step(); redirect = 1'b0;
        step(); chk("t5_pc31", 32'(if_pc), 32'd31);
        step(); chk("t5_pc0", 32'(if_pc), 32'd0);
        step(); chk("t5_pc1", 32'(if_pc), 32'd1);

        // Reset mid-run under stall, no restart without start
        stall = 1'b1; Resetn = 1'b0; step();
        chk("t6_valid", 32'(if_valid), 32'd0);
        chk("t6_instr", 32'(if_instr), 32'd0);
        chk("t6_cnt", 32'(fetch_count), 32'd0);
        Resetn = 1'b1; stall = 1'b0;
        repeat (3) step();
        chk("t6_idle_valid", 32'(if_valid), 32'd0);
        chk("t6_idle_addr", 32'(mem_addr), 32'd0);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            Resetn      = ($urandom_range(0, 149) != 0);
            start       = ($urandom_range(0, 7) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 11) == 0);
            redirect_pc = 5'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                w = 20'($urandom);
                if ($urandom_range(0, 9) == 0) w[19:16] = 4'hD;
                else if (w[19:16] == 4'hD) w[19:16] = 4'h0;
                mem[$urandom_range(0, 31)] = w;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
